// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//
// Shares one combinational ALU between two requesters. Each requester
// hands over an operation on a valid/ready request port. Grants are
// round-robin. The operands are registered and driven into the external
// ALU. out/zero are captured, and the result is returned on a valid/ready
// response port owned by the granted requester.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   reqN_valid / reqN_ready       request handshake (ready is combinational)
//   reqN_in1, reqN_in2, reqN_ctrl operation operands and ALU control code
//   respN_valid / respN_ready     response handshake
//   respN_out, respN_zero         shared result registers, meaningful under respN_valid
//   alu_in1, alu_in2, alu_control operand registers toward the ALU
//   alu_out, alu_zero             ALU result, captured while executing
//   busy                          high whenever an operation is in flight

module alu_share_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_in1,
    input  logic [DATA_W-1:0] req0_in2,
    input  logic [CTRL_W-1:0] req0_ctrl,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_in1,
    input  logic [DATA_W-1:0] req1_in2,
    input  logic [CTRL_W-1:0] req1_ctrl,

    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_out,
    output logic              resp0_zero,

    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_out,
    output logic              resp1_zero,

    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [CTRL_W-1:0] alu_control,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,

    output logic              busy
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] in1_q, in1_d;
    logic [DATA_W-1:0] in2_q, in2_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              zero_q, zero_d;

    logic grant0, grant1;
    logic resp_take;

    // On a tie, the requester that was not served last wins.
    assign grant0 = req0_valid && (!req1_valid || last_grant_q);
    assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

    assign resp_take = owner_q ? resp1_ready : resp0_ready;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        in1_d        = in1_q;
        in2_d        = in2_q;
        ctrl_d       = ctrl_q;
        res_d        = res_q;
        zero_d       = zero_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        resp0_valid  = 1'b0;
        resp1_valid  = 1'b0;
        busy         = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Gate with rst_n so nothing is accepted while reset is held.
                req0_ready = grant0 && rst_n;
                req1_ready = grant1 && rst_n;
                if (grant0) begin
                    owner_d = 1'b0;
                    in1_d   = req0_in1;
                    in2_d   = req0_in2;
                    ctrl_d  = req0_ctrl;
                    state_d = StExec;
                end else if (grant1) begin
                    owner_d = 1'b1;
                    in1_d   = req1_in1;
                    in2_d   = req1_in2;
                    ctrl_d  = req1_ctrl;
                    state_d = StExec;
                end
            end
            StExec: begin
                busy    = 1'b1;
                res_d   = alu_out;
                zero_d  = alu_zero;
                state_d = StResp;
            end
            StResp: begin
                busy        = 1'b1;
                resp0_valid = !owner_q;
                resp1_valid = owner_q;
                if (resp_take) begin
                    last_grant_d = owner_q;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            in1_q        <= '0;
            in2_q        <= '0;
            ctrl_q       <= '0;
            res_q        <= '0;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            in1_q        <= in1_d;
            in2_q        <= in2_d;
            ctrl_q       <= ctrl_d;
            res_q        <= res_d;
            zero_q       <= zero_d;
        end
    end

    assign alu_in1     = in1_q;
    assign alu_in2     = in2_q;
    assign alu_control = ctrl_q;

    assign resp0_out  = res_q;
    assign resp0_zero = zero_q;
    assign resp1_out  = res_q;
    assign resp1_zero = zero_q;

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares the single-cycle CPU's one ALU between two requesters, e.g. the main datapath and a branch/address helper unit. Each requester hands over an operation through a valid/ready request port. The arbiter grants round-robin, registers the operands, drives them into the ALU, captures `out`/`zero`, and returns the result on a valid/ready response port. The ALU itself stays purely combinational and is instantiated beside this block.

## Interface
- `DATA_W`, default 32: operand/result width.
- `CTRL_W`, default 6: ALU control width; passed through uninterpreted.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `req0_valid`, `req1_valid`  in  1  request present.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle (combinational).
- `req0_in1`, `req0_in2`, `req1_in1`, `req1_in2`  in  DATA_W  operands.
- `req0_ctrl`, `req1_ctrl`  in  CTRL_W  ALU control code.
- `resp0_valid`, `resp1_valid`  out  1  result available.
- `resp0_ready`, `resp1_ready`  in  1  requester takes result.
- `resp0_out`, `resp1_out`  out  DATA_W  result (shared register, valid only with its `respN_valid`).
- `resp0_zero`, `resp1_zero`  out  1  ALU zero flag for the result.
- `alu_in1`, `alu_in2`  out  DATA_W  to ALU `in1`/`in2`.
- `alu_control`  out  CTRL_W  to ALU `control`.
- `alu_out`  in  DATA_W  from ALU `out`.
- `alu_zero`  in  1  from ALU `zero`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - EXEC: operands registered and driving the ALU.
  - RESP: result held for the owner.
- IDLE:
  - If exactly one `reqN_valid` is high, assert that `reqN_ready` and go to EXEC.
  - If both are high, grant the requester that is not `last_grant`.
  - On accept, latch `in1`, `in2`, `ctrl` into operand registers and latch `owner`.
- EXEC: `alu_*` are driven from the operand registers. Capture `alu_out` into `res_q` and `alu_zero` into `zero_q`, then go to RESP.
- RESP:
  - `resp[owner]_valid` is high; the other `respN_valid` is low.
  - When `resp[owner]_ready` is high, set `last_grant <= owner` and go to IDLE.
  - The result is held stable while not taken.
- `reqN_ready` is low outside IDLE. Requests arriving then wait; valid must stay asserted until ready.
- `alu_in1`/`alu_in2`/`alu_control` always reflect the operand registers and change only on accept.
- `respN_out` and `respN_zero` both carry `res_q`/`zero_q`. Data is meaningful only under the matching valid.
- Reset values:
  - state = IDLE, `last_grant` = 1 (so requester 0 wins the first tie), owner = 0.
  - Operand registers, `res_q`, `zero_q` = 0.
  - All `ready`/`valid`/`busy` = 0 while `rst_n` is low.
- Reset asserted mid-operation aborts immediately. The pending op is lost and no response is produced. The requester must reissue.

## Timing
- Accept at edge T (valid and ready both high in cycle T-1→T). Cycle T is EXEC, and the result is captured at edge T+1.
- `respN_valid` is high from cycle T+1 onward.
- Minimum latency from accept to response: 2 cycles.
- Minimum issue interval: 3 cycles (IDLE, EXEC, RESP with immediate ready).
- Response handshake completes on the edge where valid and ready are both high. The next accept can occur no earlier than the following edge.
- A request held during another op is granted in the first IDLE cycle after the response is taken.
- No combinational path from `alu_out` to any output. Ready depends only on state, `reqN_valid` and `last_grant`.

## Test plan
- Single op: after reset, req0 sends `in1`=1, `in2`=1, `ctrl`=6'b000000, with `resp0_ready` tied high.
  - `req0_ready` is high for 1 cycle.
  - `alu_in1`=1, `alu_in2`=1, `alu_control`=0 during EXEC.
  - `resp0_valid` is high 2 cycles after accept, for exactly 1 cycle.
  - `resp0_out`/`resp0_zero` equal the ALU model's result for those operands.
  - `resp1_valid` stays low.
- Tie: both valid at once, req0 (`in1`=10, `ctrl`=6'b000001) and req1 (`in1`=5, `ctrl`=6'b000001), responses always ready.
  - req0 is served first, then req1 is accepted in the first IDLE cycle.
  - Responses appear in order 0 then 1, each with correct data.
  - On the next tie, req1 must not win twice in a row.
- Back-pressure: hold `resp1_ready` low for 5 cycles.
  - `resp1_valid`, `resp1_out` and `resp1_zero` stay stable.
  - `busy` stays high and `req0_ready` stays low.
  - Release: IDLE on the next edge.
- Zero flag: operands chosen so the ALU model gives `out`=0 → `resp0_zero`=1. Operands giving a nonzero result → `resp0_zero`=0.
- Reset mid-EXEC: pull `rst_n` low asynchronously during EXEC.
  - All valid/ready/busy signals go to 0 immediately.
  - After release, `alu_in*`=0 and no stale response appears.
  - The next request is served normally.
- Random soak: 1000 random ops on both ports with random valid/ready stalls.
  - Every accepted op gets exactly one response on the right port, in per-port order, matching the ALU model.
  - No port starves while the other is continuously requesting.
